// File: rtl/imem_pkg.sv
// Shared types, constants and address helpers for the instruction memory.
package imem_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  // Helpers work on a wide address; callers size-cast in and out.
  localparam int ADDR_W = 64;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_fault(input logic [ADDR_W-1:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= ADDR_W'(unsigned'(depth)));
  endfunction

endpackage

// File: rtl/imem_ram_1w1r.sv
// DEPTH x XLEN single-write / single-read RAM with registered read and write-first bypass.
module imem_ram_1w1r #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  logic                     i_clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [XLEN-1:0]          o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // The read register holds between reads so the fetch output can hold its last value.
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory: byte-addressed fetch port, programming port, NOP fill after reset.
// Define IMEM_WRITE_PROTECT_EN to add i_wp_lock and the o_wp_reject_cnt counter.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] FILL_WORD = XLEN'(RV_NOP)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_fetch_req,
  input  logic [XLEN-1:0] i_fetch_addr,
  output logic            o_fetch_ready,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_fetch_instr,
  output logic            o_fetch_fault,
  input  logic            i_prog_we,
  input  logic [XLEN-1:0] i_prog_addr,
  input  logic [XLEN-1:0] i_prog_data,
  output logic            o_prog_ack,
`ifdef IMEM_WRITE_PROTECT_EN
  input  logic            i_wp_lock,
  output logic [7:0]      o_wp_reject_cnt,
`endif
  output logic            o_init_done
);

  localparam int AW = $clog2(DEPTH);

  imem_state_t     r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_init_done;
  logic            r_valid;
  logic            r_fault;
  logic            r_have_data;
  logic            r_prog_ack;

  logic            w_run;
  logic            w_fetch_acc;
  logic            w_fetch_fault;
  logic [AW-1:0]   w_fetch_idx;
  logic            w_prog_fault;
  logic [AW-1:0]   w_prog_idx;
  logic            w_prog_ok;
  logic            w_wp_block;
  logic            w_ram_we;
  logic [AW-1:0]   w_ram_waddr;
  logic [XLEN-1:0] w_ram_wdata;
  logic            w_ram_re;
  logic [XLEN-1:0] w_ram_rdata;

  assign w_run         = (r_state == RUN);
  assign w_fetch_fault = addr_fault(ADDR_W'(i_fetch_addr), DEPTH);
  assign w_fetch_idx   = AW'(word_index(ADDR_W'(i_fetch_addr)));
  assign w_prog_fault  = addr_fault(ADDR_W'(i_prog_addr), DEPTH);
  assign w_prog_idx    = AW'(word_index(ADDR_W'(i_prog_addr)));

`ifdef IMEM_WRITE_PROTECT_EN
  assign w_wp_block = i_wp_lock;
`else
  assign w_wp_block = 1'b0;
`endif

  assign w_fetch_acc = i_fetch_req & w_run;
  assign w_prog_ok   = w_run & i_prog_we & ~w_prog_fault & ~w_wp_block;
  // Faulting fetches never touch the array.
  assign w_ram_re    = w_fetch_acc & ~w_fetch_fault;

  always_comb begin
    w_ram_we    = 1'b1;
    w_ram_waddr = r_cnt;
    w_ram_wdata = FILL_WORD;
    if (w_run) begin
      w_ram_we    = w_prog_ok;
      w_ram_waddr = w_prog_idx;
      w_ram_wdata = i_prog_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_have_data <= 1'b0;
      r_prog_ack  <= 1'b0;
    end else begin
      r_valid    <= w_fetch_acc;
      r_prog_ack <= w_prog_ok;
      if (w_fetch_acc) begin
        r_fault     <= w_fetch_fault;
        r_have_data <= 1'b1;
      end
      if (!w_run) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == AW'(DEPTH - 1)) begin
          r_state     <= RUN;
          r_init_done <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_WRITE_PROTECT_EN
  logic [7:0] r_wp_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wp_cnt <= 8'd0;
    end else if (w_run && i_prog_we && i_wp_lock && (r_wp_cnt != 8'hFF)) begin
      r_wp_cnt <= r_wp_cnt + 8'd1;
    end
  end

  assign o_wp_reject_cnt = r_wp_cnt;
`endif

  imem_ram_1w1r #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clock (i_clock),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_fetch_idx),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register has no reset, so the output reads zero until the first fetch.
  assign o_fetch_instr = !r_have_data ? '0 : (r_fault ? FILL_WORD : w_ram_rdata);
  assign o_fetch_valid = r_valid;
  assign o_fetch_fault = r_fault;
  assign o_fetch_ready = w_run;
  assign o_prog_ack    = r_prog_ack;
  assign o_init_done   = r_init_done;

endmodule
